shift_exec_stage: RTL

- Registered execute stage around the 8-bit combinational barrel shifter.
- Accepts shift/rotate micro-ops from decode over a valid/ready handshake and computes the result, carry and zero flags.
- Holds results in a 2-entry output buffer for writeback to the register file.
- Decouples decode from writeback stalls; in_ready depends only on registered state.

---
 rtl/shift_exec_stage_pkg.sv | 20 ++
 rtl/shift_core.sv | 80 ++++++++
 rtl/shift_exec_stage.sv | 105 ++++++++++
 3 files changed

// File: rtl/shift_exec_stage_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// shift_exec_stage_pkg : op codes, default widths and buffer depth
// Revision: 1.0
// ---------------------------------------------------------------------------
package shift_exec_stage_pkg;

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_SHW   = 3;
  localparam int DEF_RDW   = 3;

  localparam int BUF_DEPTH = 2;

endpackage
`default_nettype wire

// File: rtl/shift_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// shift_core : combinational 3-layer log shifter (SRL/SLL/SRA, ROR when
// SHIFT_EXEC_ROTATE_EN is defined, otherwise op 11 behaves as SRL)
// Revision: 1.0
// ---------------------------------------------------------------------------
module shift_core
  import shift_exec_stage_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHW   = DEF_SHW
) (
  input  logic [WIDTH-1:0] data,
  input  logic [SHW-1:0]   amt,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [1:0]       w_op_eff;
  logic             w_is_left;
  logic             w_is_rot;
  logic             w_sign;
  logic [WIDTH-1:0] w_l1;
  logic [WIDTH-1:0] w_l2;
  logic [WIDTH-1:0] w_l3;
  logic [SHW-1:0]   w_idx_right;
  logic [SHW-1:0]   w_idx_left;

`ifdef SHIFT_EXEC_ROTATE_EN
  assign w_op_eff = op;
  assign w_is_rot = (op == OP_ROR);
`else
  assign w_op_eff = (op == OP_ROR) ? OP_SRL : op;
  assign w_is_rot = 1'b0;
`endif

  assign w_is_left = (w_op_eff == OP_SLL);
  assign w_sign    = (w_op_eff == OP_SRA) & data[WIDTH-1];

  // One mux layer: right shifts pull fill bits in from the top, either the
  // wrapped-around low bits (rotate) or replicated sign/zero.
  function automatic logic [WIDTH-1:0] layer(
    input logic [WIDTH-1:0] v,
    input logic             en,
    input int               sh,
    input logic             left,
    input logic             sign,
    input logic             rot
  );
    logic [WIDTH-1:0] fill;
    if (!en) return v;
    if (left) return v << sh;
    fill = rot ? (v << (WIDTH - sh)) : ({WIDTH{sign}} << (WIDTH - sh));
    return (v >> sh) | fill;
  endfunction

  assign w_l1   = layer(data, amt[0], 1, w_is_left, w_sign, w_is_rot);
  assign w_l2   = layer(w_l1, amt[1], 2, w_is_left, w_sign, w_is_rot);
  assign w_l3   = layer(w_l2, amt[2], 4, w_is_left, w_sign, w_is_rot);
  assign result = w_l3;

  // Left index wraps to WIDTH-amt modulo 2**SHW.
  assign w_idx_right = amt - 1'b1;
  assign w_idx_left  = -amt;

  always_comb begin
    carry = 1'b0;
    if (amt != '0) begin
      if (w_is_rot)
        carry = w_l3[WIDTH-1];
      else if (w_op_eff == OP_SRL || w_op_eff == OP_SRA)
        carry = data[w_idx_right];
      else
        carry = data[w_idx_left];
    end
  end

endmodule
`default_nettype wire

// File: rtl/shift_exec_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// shift_exec_stage : registered shift execute stage with 2-entry result buffer
// Optional macro: SHIFT_EXEC_ROTATE_EN (enables ROR on op 11)
// Revision: 1.0
// ---------------------------------------------------------------------------
module shift_exec_stage
  import shift_exec_stage_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHW   = DEF_SHW,
  parameter int RDW   = DEF_RDW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_op,
  input  logic [RDW-1:0]   in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero,
  output logic [RDW-1:0]   out_rd
);

  localparam logic [1:0] CNT_EMPTY = 2'd0;
  localparam logic [1:0] CNT_ONE   = 2'd1;
  localparam logic [1:0] CNT_FULL  = 2'd2;

  logic [1:0]       r_count;
  logic             r_head;
  logic             r_tail;
  logic [WIDTH-1:0] r_buf_data  [BUF_DEPTH];
  logic             r_buf_carry [BUF_DEPTH];
  logic             r_buf_zero  [BUF_DEPTH];
  logic [RDW-1:0]   r_buf_rd    [BUF_DEPTH];

  logic [WIDTH-1:0] w_result;
  logic             w_carry;
  logic             w_accept;
  logic             w_pop;

  shift_core #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_core (
    .data   (in_data),
    .amt    (in_amt),
    .op     (in_op),
    .result (w_result),
    .carry  (w_carry)
  );

  // Ready comes from the count register only, so writeback stalls never
  // combinationally reach decode.
  assign in_ready  = !rst && (r_count != CNT_FULL);
  assign out_valid = (r_count != CNT_EMPTY);
  assign w_accept  = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= CNT_EMPTY;
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_buf_data[i]  <= '0;
        r_buf_carry[i] <= 1'b0;
        r_buf_zero[i]  <= 1'b0;
        r_buf_rd[i]    <= '0;
      end
    end else if (in_flush) begin
      r_count <= CNT_EMPTY;
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_buf_data[r_tail]  <= w_result;
        r_buf_carry[r_tail] <= w_carry;
        r_buf_zero[r_tail]  <= (w_result == '0);
        r_buf_rd[r_tail]    <= in_rd;
        r_tail              <= ~r_tail;
      end
      if (w_pop)
        r_head <= ~r_head;
      case ({w_accept, w_pop})
        2'b10:   r_count <= (r_count == CNT_EMPTY) ? CNT_ONE : CNT_FULL;
        2'b01:   r_count <= (r_count == CNT_FULL) ? CNT_ONE : CNT_EMPTY;
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_data  = out_valid ? r_buf_data[r_head]  : '0;
  assign out_carry = out_valid ? r_buf_carry[r_head] : 1'b0;
  assign out_zero  = out_valid ? r_buf_zero[r_head]  : 1'b0;
  assign out_rd    = out_valid ? r_buf_rd[r_head]    : '0;

endmodule
`default_nettype wire
